// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// responder FSM states and the access-legality check.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width/sign/direction/alignment legality; the address-range check lives in the top.
  function automatic logic is_legal_access(input logic [2:0] f3,
                                           input logic       is_write,
                                           input logic [1:0] lane);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = ~is_write;
      F3_H:    ok = ~lane[0];
      F3_HU:   ok = ~is_write & ~lane[0];
      F3_W:    ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: extracts and extends load data, and
// merges store data into the old word with per-byte enables.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_load_word,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word,
  output logic [3:0]  o_byte_en
);

  logic [31:0] w_shifted;
  logic [31:0] w_repl;

  always_comb begin
    w_shifted = i_load_word >> {i_lane, 3'b000};
    case (i_f3)
      F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_load_data = w_shifted;
      F3_BU:   o_load_data = {24'h0, w_shifted[7:0]};
      F3_HU:   o_load_data = {16'h0, w_shifted[15:0]};
      default: o_load_data = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the enable mask alone picks the target bytes.
  always_comb begin
    case (i_f3)
      F3_B: begin
        o_byte_en = 4'b0001 << i_lane;
        w_repl    = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_byte_en = 4'b0011 << i_lane;
        w_repl    = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        o_byte_en = 4'b1111;
        w_repl    = i_wdata;
      end
      default: begin
        o_byte_en = 4'b0000;
        w_repl    = 32'h0;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      o_store_word[8*b +: 8] = o_byte_en[b] ? w_repl[8*b +: 8] : i_old_word[8*b +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// latency, then pulses ready (and err for illegal accesses).
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          read_mem,
  input  logic          write_mem,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [2:0]    lorbtype,
  input  logic          init_we,
  input  logic [AW-1:0] init_addr,
  input  logic [31:0]   init_data,
  output logic [31:0]   rdata,
  output logic          ready,
  output logic          busy,
  output logic          err
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [2:0]    r_f3;
  logic [31:0]   r_wdata;
  logic          r_write;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_req_err;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [2:0]    w_f3;
  logic [31:0]   w_wdata;
  logic [31:0]   w_mem_word;
  logic [31:0]   w_load_data;
  logic [31:0]   w_store_word;
  logic [3:0]    w_byte_en;

  assign w_req     = read_mem | write_mem;
  assign w_req_err = (read_mem & write_mem)
                   | ~is_legal_access(lorbtype, write_mem, addr[1:0])
                   | (addr[31:AW+2] != '0);

  // In IDLE the live request feeds the lane logic so LATENCY=1 can respond straight away.
  assign w_idx      = (r_state == IDLE) ? addr[AW+1:2] : r_idx;
  assign w_lane     = (r_state == IDLE) ? addr[1:0]    : r_lane;
  assign w_f3       = (r_state == IDLE) ? lorbtype     : r_f3;
  assign w_wdata    = (r_state == IDLE) ? wdata        : r_wdata;
  assign w_mem_word = r_mem[w_idx];

  dmem_lane_align u_align (
    .i_load_word  (w_mem_word),
    .i_old_word   (w_mem_word),
    .i_wdata      (w_wdata),
    .i_lane       (w_lane),
    .i_f3         (w_f3),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word),
    .o_byte_en    (w_byte_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_lane  <= '0;
      r_f3    <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (w_req) begin
            r_idx   <= addr[AW+1:2];
            r_lane  <= addr[1:0];
            r_f3    <= lorbtype;
            r_wdata <= wdata;
            r_write <= write_mem;
            r_err   <= w_req_err;
            r_cnt   <= CW'(LATENCY - 1);
            busy    <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= RESP;
              ready   <= 1'b1;
              err     <= w_req_err;
              if (w_req_err)       rdata <= '0;
              else if (!write_mem) rdata <= w_load_data;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
            ready   <= 1'b1;
            err     <= r_err;
            if (r_err)         rdata <= '0;
            else if (!r_write) rdata <= w_load_data;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          ready   <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stores commit on the edge leaving RESP; preload only when IDLE and no request.
  always_ff @(posedge clk) begin
    if (r_state == RESP && r_write && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) r_mem[r_idx][8*b +: 8] <= w_store_word[8*b +: 8];
      end
    end else if (r_state == IDLE && !w_req && init_we) begin
      r_mem[init_addr] <= init_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-addressed reference model,
// per-cycle comparison of ready/busy/err/rdata, directed plus random traffic.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read_mem = 1'b0;
  logic          write_mem = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [2:0]    lorbtype = '0;
  logic          init_we = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [31:0]   init_data = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic          busy;
  logic          err;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          edgeCnt = 0;
  int          acc = -1000;
  bit          checkEn = 1'b0;
  bit          expErr = 1'b0;
  bit          expStore = 1'b0;
  logic [31:0] expData = '0;
  logic [31:0] lastRdata = '0;
  logic [31:0] seenRdata = '0;
  logic        seenErr = 1'b0;
  logic [7:0]  mb [0:4*DEPTH-1];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_mem  (read_mem),
    .write_mem (write_mem),
    .addr      (addr),
    .wdata     (wdata),
    .lorbtype  (lorbtype),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .rdata     (rdata),
    .ready     (ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgeCnt);
    end
  endtask

  // Reference model: byte-addressed memory and the legality rules written out directly.
  task automatic modelAccess(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [2:0] f3, output bit e, output logic [31:0] r);
    int size;
    bit sgn;
    r = 32'h0;
    e = 1'b0;
    case (f3)
      3'b000:  begin size = 1; sgn = 1'b1; end
      3'b001:  begin size = 2; sgn = 1'b1; end
      3'b010:  begin size = 4; sgn = 1'b0; end
      3'b100:  begin size = 1; sgn = 1'b0; end
      3'b101:  begin size = 2; sgn = 1'b0; end
      default: begin size = 0; sgn = 1'b0; end
    endcase
    if (size == 0 || (wr && f3[2])) e = 1'b1;
    if (rd && wr) e = 1'b1;
    if (size > 1 && (a % size) != 0) e = 1'b1;
    if ((a >> 2) >= DEPTH) e = 1'b1;
    if (!e && rd) begin
      for (int i = 0; i < size; i++) r = r | (32'(mb[a + i]) << (8 * i));
      if (sgn && r[8*size-1]) r = r | (32'hFFFF_FFFF << (8 * size));
    end
  endtask

  task automatic modelStore(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    int size;
    size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    for (int i = 0; i < size; i++) mb[a + i] = 8'(wd >> (8 * i));
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk); #1;
    init_we = 1'b1;
    init_addr = AW'(idx);
    init_data = data;
    @(negedge clk); #1;
    init_we = 1'b0;
    for (int i = 0; i < 4; i++) mb[4*idx + i] = 8'(data >> (8 * i));
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [2:0] f3,
                               input bit hold, input bit junkInit);
    bit e;
    logic [31:0] r;
    @(negedge clk); #1;
    modelAccess(rd, wr, a, f3, e, r);
    expErr = e;
    expData = e ? 32'h0 : r;
    expStore = wr && !rd;
    read_mem = rd;
    write_mem = wr;
    addr = a;
    wdata = wd;
    lorbtype = f3;
    if (junkInit) begin
      init_we = 1'b1;
      init_addr = AW'($urandom);
      init_data = $urandom;
    end
    acc = edgeCnt + 1;
    repeat (LAT + 1) @(negedge clk);
    #1;
    if (!e && wr) modelStore(a, wd, f3);
    if (hold) begin
      acc = acc + LAT + 2;
      repeat (LAT + 2) @(negedge clk);
      #1;
    end
    read_mem = 1'b0;
    write_mem = 1'b0;
    init_we = 1'b0;
  endtask

  always @(negedge clk) begin
    bit er;
    bit eb;
    if (checkEn) begin
      er = (edgeCnt == acc + LAT);
      eb = (edgeCnt >= acc) && (edgeCnt <= acc + LAT);
      checkOutput("ready", ready, 32'(er));
      checkOutput("busy", busy, 32'(eb));
      if (er) begin
        checkOutput("err", err, 32'(expErr));
        seenRdata = rdata;
        seenErr = err;
        if (!expStore || expErr) begin
          checkOutput("rdata", rdata, expData);
          lastRdata = expData;
        end
      end else begin
        checkOutput("err idle", err, 32'h0);
        checkOutput("rdata hold", rdata, lastRdata);
      end
    end
  end

  initial begin
    bit rd, wr;
    logic [31:0] a;
    logic [2:0] f3;
    logic [2:0] legalF3 [5];
    legalF3[0] = 3'b000; legalF3[1] = 3'b001; legalF3[2] = 3'b010;
    legalF3[3] = 3'b100; legalF3[4] = 3'b101;

    repeat (2) @(negedge clk);
    checkOutput("reset ready", ready, 32'h0);
    checkOutput("reset busy", busy, 32'h0);
    checkOutput("reset err", err, 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    #1 rst_n = 1'b1;
    checkEn = 1'b1;

    preload(1, 32'h8081_7F01);
    applyStimulus(1, 0, 32'd4, 0, 3'b000, 0, 0);
    checkOutput("LB@4", seenRdata, 32'h0000_0001);
    applyStimulus(1, 0, 32'd5, 0, 3'b100, 0, 0);
    checkOutput("LBU@5", seenRdata, 32'h0000_007F);
    applyStimulus(1, 0, 32'd6, 0, 3'b001, 0, 0);
    checkOutput("LH@6", seenRdata, 32'hFFFF_8081);
    applyStimulus(1, 0, 32'd6, 0, 3'b101, 0, 0);
    checkOutput("LHU@6", seenRdata, 32'h0000_8081);
    applyStimulus(1, 0, 32'd4, 0, 3'b010, 0, 0);
    checkOutput("LW@4", seenRdata, 32'h8081_7F01);

    preload(2, 32'h1122_3344);
    applyStimulus(0, 1, 32'd9, 32'h0000_00AA, 3'b000, 0, 0);
    applyStimulus(1, 0, 32'd8, 0, 3'b010, 0, 0);
    checkOutput("LW@8 after SB", seenRdata, 32'h1122_AA44);
    applyStimulus(0, 1, 32'd10, 32'h0000_BEEF, 3'b001, 0, 0);
    applyStimulus(1, 0, 32'd8, 0, 3'b010, 0, 0);
    checkOutput("LW@8 after SH", seenRdata, 32'hBEEF_AA44);

    applyStimulus(1, 0, 32'd6, 0, 3'b010, 0, 0);
    checkOutput("LW@6 err", seenErr, 32'h1);
    applyStimulus(0, 1, 32'd3, 32'h0000_1234, 3'b001, 0, 0);
    checkOutput("SH@3 err", seenErr, 32'h1);
    applyStimulus(1, 0, 32'd4, 0, 3'b011, 0, 0);
    checkOutput("f3=011 err", seenErr, 32'h1);
    applyStimulus(1, 0, 32'(4 * DEPTH), 0, 3'b010, 0, 0);
    checkOutput("LW range err", seenErr, 32'h1);
    applyStimulus(1, 0, 32'd4, 0, 3'b010, 0, 0);
    checkOutput("LW@4 unchanged", seenRdata, 32'h8081_7F01);

    preload(3, 32'h5566_7788);
    @(negedge clk); #1;
    write_mem = 1'b1;
    addr = 32'd12;
    wdata = 32'hDEAD_BEEF;
    lorbtype = 3'b010;
    expStore = 1'b1;
    expErr = 1'b0;
    acc = edgeCnt + 1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    acc = -1000;
    lastRdata = 32'h0;
    write_mem = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1, 0, 32'd12, 0, 3'b010, 0, 0);
    checkOutput("LW@12 after reset", seenRdata, 32'h5566_7788);

    applyStimulus(1, 1, 32'd12, 32'hFFFF_FFFF, 3'b010, 0, 0);
    checkOutput("rd+wr err", seenErr, 32'h1);
    applyStimulus(1, 0, 32'd12, 0, 3'b010, 0, 0);
    checkOutput("LW@12 no write", seenRdata, 32'h5566_7788);
    applyStimulus(1, 0, 32'd4, 0, 3'b010, 1, 0);
    checkOutput("held LW second", seenRdata, 32'h8081_7F01);

    for (int i = 0; i < 16; i++) preload(i, $urandom);
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 19))
        0:       begin rd = 1'b1; wr = 1'b1; end
        1, 2, 3, 4, 5, 6, 7, 8, 9: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b0; end
      endcase
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                        : legalF3[$urandom_range(0, 4)];
      applyStimulus(rd, wr, a, $urandom, f3,
                    rd && !wr && ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
